uart_rx_fifo_param: RTL
=======================

Name: uart_rx_fifo_param

Overview:
Parametrised receiver FIFO for the UART core, used between the RX shift/sample logic and the register interface. Each entry holds received data plus per-character error flags (parity, framing, break). It generalises depth and width and adds sticky overrun/underrun flags and a synchronous clear. A 16550-style trigger-level comparator and a running error-entry counter drive LSR bit 7 without OR-ing across all storage words.

Parameters:
DATA_W, 8, data bits per character
ERR_W, 3, error flags per entry: bit0 parity, bit1 framing, bit2 break
ADDR_W, 4, pointer width; DEPTH = 2**ADDR_W entries (min ADDR_W = 2)

Ports:
clk  in  1  system clock, all state on rising edge
wb_rst_i  in  1  asynchronous reset, active high
data_in  in  DATA_W+ERR_W  {data, err}; err in LSBs [ERR_W-1:0]
push  in  1  write strobe, one entry per high cycle
pop  in  1  read strobe, one entry per high cycle
fifo_clr  in  1  synchronous flush (FCR bit 1)
status_clr  in  1  clears sticky overrun/underrun (LSR read)
trig_sel  in  2  trigger level select
data_out  out  DATA_W+ERR_W  head entry (first-word fall-through)
count  out  ADDR_W+1  entries held, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
overrun  out  1  sticky: push attempted while full
underrun  out  1  sticky: pop attempted while empty
error_bit  out  1  at least one held entry has any err flag set
trig_hit  out  1  count >= selected trigger level

Behaviour:
- Reset (async, wb_rst_i high): rd_ptr=0, wr_ptr=0, count=0, err_cnt=0, overrun=0, underrun=0. Outputs: empty=1, full=0, error_bit=0, trig_hit=0. Storage array is not reset. data_out is don't-care while empty.
- Storage: DEPTH x (DATA_W+ERR_W) regs. Pointers ADDR_W bits, wrap naturally modulo DEPTH.
- data_out = mem[rd_ptr], combinational from registered state. Valid whenever empty=0. A popped entry leaves data_out on the next cycle.
- Push accepted if push && (!full || pop): mem[wr_ptr] <= data_in, wr_ptr++.
- Pop accepted if pop && !empty: rd_ptr++.
- count updates on accepted ops only: +1 for push only, -1 for pop only, unchanged for both or neither.
- Full boundary: push&&!pop while full -> data dropped, pointers/count unchanged, overrun<=1. push&&pop while full -> both accepted, count stays DEPTH, no overrun.
- Empty boundary: pop while empty -> ignored, underrun<=1. push&&pop while empty -> push accepted, pop ignored, count=1, underrun<=1.
- err_cnt (ADDR_W+1 bits) tracks held entries with |err != 0:
  - +1 on an accepted push of such an entry.
  - -1 on an accepted pop whose head entry has |err != 0.
  - Both in the same cycle: unchanged.
  - error_bit = (err_cnt != 0), registered-state derived. Dropped (overrun) pushes never count.
- Sticky flags: set per the rules above. status_clr clears them. If a set and status_clr occur in the same cycle, set wins.
- fifo_clr: next edge sets pointers, count, err_cnt, overrun and underrun to 0. Takes priority over push/pop/status_clr in the same cycle; a coincident push is discarded.
- Trigger level L by trig_sel: 0 -> 1, 1 -> DEPTH/4, 2 -> DEPTH/2, 3 -> DEPTH-2. trig_hit = (count >= L), combinational.
- Single-cycle latency: a push at edge N is visible on data_out/count after edge N when the FIFO was empty.

Test Plan:
- Reset, then push 0x41/err=0 and 0x42/err=0b010 on consecutive cycles -> count=2, data_out=0x41, error_bit=1. Pop twice -> error_bit drops to 0 after the second pop, empty=1.
- ADDR_W=4: push 17 entries with no pops -> count=16, full=1, overrun=1, 17th entry absent. Pop 16 -> values in order 0..15.
- Full FIFO with push&&pop held for 40 cycles (pointer wrap) -> count stays 16, overrun=0, data order preserved.
- Pop on empty -> underrun=1, count=0. status_clr -> underrun=0. status_clr coincident with a new empty pop -> underrun stays 1.
- trig_sel=3, DEPTH=16: push 13 -> trig_hit=0; push 14th -> trig_hit=1. trig_sel=0 with count=1 -> trig_hit=1.
- Hold 5 entries, 2 with errors, then fifo_clr together with push -> next cycle count=0, err_cnt=0, error_bit=0, overrun=0. Mid-operation async reset -> same values immediately.

Source files
------------

// File: rtl/uart_rx_fifo_param.sv
// ============================================================================
// Module   : uart_rx_fifo_param
// Brief    : UART RX FIFO with per-entry error flags, sticky over/underrun,
//            trigger-level compare and running error-entry counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo_param #(
  parameter int DATA_W = 8,
  parameter int ERR_W  = 3,
  parameter int ADDR_W = 4
) (
  input  logic                      clk,
  input  logic                      wb_rst_i,
  input  logic [DATA_W+ERR_W-1:0]   data_in,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      fifo_clr,
  input  logic                      status_clr,
  input  logic [1:0]                trig_sel,
  output logic [DATA_W+ERR_W-1:0]   data_out,
  output logic [ADDR_W:0]           count,
  output logic                      empty,
  output logic                      full,
  output logic                      overrun,
  output logic                      underrun,
  output logic                      error_bit,
  output logic                      trig_hit
);

  localparam int W     = DATA_W + ERR_W;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_depth   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_lvl_q   = CNT_W'(DEPTH / 4);
  localparam logic [CNT_W-1:0] c_lvl_h   = CNT_W'(DEPTH / 2);
  localparam logic [CNT_W-1:0] c_lvl_top = CNT_W'(DEPTH - 2);

  logic [W-1:0]      mem [DEPTH];

  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;

  logic              w_empty, w_full;
  logic              w_push_ok, w_pop_ok;
  logic              w_in_err, w_head_err;
  logic              w_set_ovr, w_set_und;
  logic [CNT_W-1:0]  w_trig_lvl;

  assign w_empty    = (count_q == '0);
  assign w_full     = (count_q == c_depth);
  assign w_in_err   = |data_in[ERR_W-1:0];
  assign w_head_err = |mem[rd_ptr_q][ERR_W-1:0];

  always_comb begin
    w_push_ok  = push && (!w_full || pop);
    w_pop_ok   = pop && !w_empty;
    w_set_ovr  = push && !w_push_ok;
    w_set_und  = pop && w_empty;

    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    err_cnt_d  = err_cnt_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;

    if (fifo_clr) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      err_cnt_d  = '0;
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end else begin
      if (w_push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;

      if (w_push_ok && !w_pop_ok)      count_d = count_q + c_one;
      else if (w_pop_ok && !w_push_ok) count_d = count_q - c_one;

      // Error count follows entries entering and leaving, not the storage.
      if ((w_push_ok && w_in_err) && !(w_pop_ok && w_head_err))
        err_cnt_d = err_cnt_q + c_one;
      else if ((w_pop_ok && w_head_err) && !(w_push_ok && w_in_err))
        err_cnt_d = err_cnt_q - c_one;

      if (w_set_ovr)       overrun_d = 1'b1;
      else if (status_clr) overrun_d = 1'b0;

      if (w_set_und)       underrun_d = 1'b1;
      else if (status_clr) underrun_d = 1'b0;
    end
  end

  always_comb begin
    w_trig_lvl = c_one;
    case (trig_sel)
      2'd0:    w_trig_lvl = c_one;
      2'd1:    w_trig_lvl = c_lvl_q;
      2'd2:    w_trig_lvl = c_lvl_h;
      default: w_trig_lvl = c_lvl_top;
    endcase
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      err_cnt_q  <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      err_cnt_q  <= err_cnt_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage is intentionally unreset; a flush discards the write.
  always_ff @(posedge clk) begin
    if (w_push_ok && !fifo_clr) mem[wr_ptr_q] <= data_in;
  end

  assign data_out  = mem[rd_ptr_q];
  assign count     = count_q;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overrun   = overrun_q;
  assign underrun  = underrun_q;
  assign error_bit = (err_cnt_q != '0);
  assign trig_hit  = (count_q >= w_trig_lvl);

endmodule

`default_nettype wire
